// File: rtl/wdf_rd_arb.sv
// rtl/wdf_rd_arb.sv - WDF read-port arbiter between SRQ and MMIO with parity check and tagged data return
// SRQ wins ties until the MMIO starvation streak saturates; bad-parity grants are acked but never issued.
module wdf_rd_arb #(
  parameter int PTR_W      = 3,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              srq_wdf_rd,
  input  logic [PTR_W-1:0]  srq_wdf_ptr,
  input  logic              srq_wdf_p,
  output logic              srq_wdf_ack,
  output logic              srq_rdata_v,
  output logic [DATA_W-1:0] srq_rdata,
  input  logic              mmio_wdf_rd,
  input  logic [PTR_W-1:0]  mmio_wdf_rptr,
  input  logic              mmio_wdf_rd_p,
  output logic              mmio_wdf_ack,
  output logic              mmio_rdata_v,
  output logic [DATA_W-1:0] mmio_rdata,
  output logic              arb_wdf_rd,
  output logic [PTR_W-1:0]  arb_wdf_ptr,
  output logic              arb_wdf_p,
  input  logic [DATA_W-1:0] wdf_arb_data,
  output logic [1:0]        arb_perr
);

  localparam int STRK_W = $clog2(STARVE_MAX + 1);

  logic [STRK_W-1:0] streak;
  logic              grant_srq;
  logic              grant_mmio;
  logic              srq_bad;
  logic              mmio_bad;
  logic              issue_v;
  logic              issue_src;
  logic [PTR_W-1:0]  issue_ptr;

  // Tag stage k is live RD_LAT-k cycles before its data; stage RD_LAT lines up with wdf_arb_data.
  logic [RD_LAT:0]   tag_v;
  logic [RD_LAT:0]   tag_src;

  always_comb begin
    grant_srq  = 1'b0;
    grant_mmio = 1'b0;
    if (!rst) begin
      if (srq_wdf_rd && (!mmio_wdf_rd || streak != STRK_W'(STARVE_MAX)))
        grant_srq = 1'b1;
      else if (mmio_wdf_rd)
        grant_mmio = 1'b1;
    end
  end

  always_comb begin
    srq_bad   = srq_wdf_p != ^srq_wdf_ptr;
    mmio_bad  = mmio_wdf_rd_p != ^mmio_wdf_rptr;
    issue_v   = (grant_srq && !srq_bad) || (grant_mmio && !mmio_bad);
    issue_src = grant_mmio;
    issue_ptr = grant_mmio ? mmio_wdf_rptr : srq_wdf_ptr;
  end

  assign srq_wdf_ack  = grant_srq;
  assign mmio_wdf_ack = grant_mmio;
  assign arb_wdf_p    = ^arb_wdf_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!mmio_wdf_rd || grant_mmio) begin
      streak <= '0;
    end else if (grant_srq && streak != STRK_W'(STARVE_MAX)) begin
      streak <= streak + STRK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_wdf_rd  <= 1'b0;
      arb_wdf_ptr <= '0;
      arb_perr    <= 2'b00;
    end else begin
      arb_wdf_rd <= issue_v;
      if (issue_v)
        arb_wdf_ptr <= issue_ptr;
      arb_perr[0] <= arb_perr[0] | (grant_srq & srq_bad);
      arb_perr[1] <= arb_perr[1] | (grant_mmio & mmio_bad);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v   <= '0;
      tag_src <= '0;
    end else begin
      tag_v[0]   <= issue_v;
      tag_src[0] <= issue_src;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_src[i] <= tag_src[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      srq_rdata_v  <= 1'b0;
      mmio_rdata_v <= 1'b0;
      srq_rdata    <= '0;
      mmio_rdata   <= '0;
    end else begin
      srq_rdata_v  <= tag_v[RD_LAT] && !tag_src[RD_LAT];
      mmio_rdata_v <= tag_v[RD_LAT] && tag_src[RD_LAT];
      if (tag_v[RD_LAT] && !tag_src[RD_LAT])
        srq_rdata <= wdf_arb_data;
      if (tag_v[RD_LAT] && tag_src[RD_LAT])
        mmio_rdata <= wdf_arb_data;
    end
  end

endmodule
